// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller beside ID: RAW load-use/no-forward stalls, redirect flushes, EX operand selects.
// Latency: strobes are combinational on ID inputs; forwarding selects and the scoreboard update one edge later.
// Backpressure: enable=0 freezes every register and masks all strobes; redirect overrides stall.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W       = 5,
    parameter int FWD_EN           = 1,
    parameter int RF_WRITE_THROUGH = 1,
    parameter int CNT_W            = 16
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  enable,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic [REG_ADDR_W-1:0] id_waddr,
    input  logic                  redirect,
    input  logic                  stall_cnt_clr,
    output logic                  stall_if_id,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  flush_ex_mem,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef struct packed {
        logic                  vld;
        logic                  reg_write;
        logic                  mem_read;
        logic [REG_ADDR_W-1:0] waddr;
    } sb_ent_t;

    sb_ent_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       haz_a, haz_b, stall_raw, live;
    logic [1:0] sel_a, sel_b;

    // Returns {stall_request, select} for one source operand.
    function automatic logic [2:0] src_eval(
        input logic                  use_src,
        input logic                  vld_id,
        input logic [REG_ADDR_W-1:0] addr,
        input sb_ent_t               ex,
        input sb_ent_t               mem,
        input sb_ent_t               wb
    );
        logic       m_ex, m_mem, m_wb, hz;
        logic [1:0] sel;
        m_ex  = use_src & vld_id & ex.vld  & ex.reg_write  & (ex.waddr  != '0) & (ex.waddr  == addr);
        m_mem = use_src & vld_id & mem.vld & mem.reg_write & (mem.waddr != '0) & (mem.waddr == addr);
        m_wb  = use_src & vld_id & wb.vld  & wb.reg_write  & (wb.waddr  != '0) & (wb.waddr  == addr);
        hz    = 1'b0;
        sel   = 2'd0;
        if (FWD_EN != 0) begin
            if (m_ex) begin
                if (ex.mem_read) hz  = 1'b1;
                else             sel = 2'd1;
            end else if (m_mem) begin
                sel = 2'd2;
            end else if (m_wb && (RF_WRITE_THROUGH == 0)) begin
                hz = 1'b1;
            end
        end else begin
            hz = m_ex | m_mem | (m_wb & (RF_WRITE_THROUGH == 0));
        end
        return {hz, sel};
    endfunction

    always_comb begin
        {haz_a, sel_a} = src_eval(id_uses_rs, id_valid, id_rs, ex_q, mem_q, wb_q);
        {haz_b, sel_b} = src_eval(id_uses_rt, id_valid, id_rt, ex_q, mem_q, wb_q);
        stall_raw = (haz_a | haz_b) & ~redirect;
        live      = enable & ~arst;

        stall_if_id  = live & stall_raw;
        flush_if_id  = live & redirect;
        flush_ex_mem = live & redirect;
        flush_id_ex  = live & (stall_raw | redirect);

        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        cnt_d   = cnt_q;

        if (enable) begin
            wb_d = mem_q;
            if (redirect) begin
                ex_d  = '0;
                mem_d = '0;
            end else if (stall_raw) begin
                ex_d  = '0;
                mem_d = ex_q;
            end else begin
                ex_d  = '{vld: id_valid, reg_write: id_reg_write, mem_read: id_mem_read, waddr: id_waddr};
                mem_d = ex_q;
            end
            // A bubble entering EX must not pull a forwarded operand.
            fwd_a_d = (stall_raw | redirect) ? 2'd0 : sel_a;
            fwd_b_d = (stall_raw | redirect) ? 2'd0 : sel_b;
        end

        if (stall_cnt_clr) begin
            cnt_d = '0;
        end else if (enable && stall_raw && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= 2'd0;
            fwd_b_q <= 2'd0;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;
    assign stall_cnt = cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipelined cpu (IF, ID, EX, MEM, WB); adds the data-hazard and control-hazard handling the current pipeline lacks.
- Keeps a 3-entry scoreboard mirroring the ID/EX, EX/MEM and MEM/WB registers.
- Produces stall/flush strobes for the pipeline registers and registered forwarding selects for the two EX operand muxes.
- Sits beside the ID stage.
- Branch/jump redirect is resolved from the EX/MEM register.

Parameters:
- REG_ADDR_W, 5: register-file address width.
- FWD_EN, 1: 1 = forward EX/MEM and MEM/WB results; 0 = stall on every RAW hazard.
- RF_WRITE_THROUGH, 1: 1 = register file returns same-cycle write data; 0 = a WB-stage producer also causes a stall.
- CNT_W, 16: stall-counter width.

Ports:
- clk  in  1  main clock.
- arst  in  1  asynchronous reset, active-high.
- enable  in  1  pipeline advance; same signal as the pipeline registers.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_ADDR_W  source 1 (instr[25:21]).
- id_rt  in  REG_ADDR_W  source 2 (instr[20:16]).
- id_uses_rs  in  1  instruction reads rs.
- id_uses_rt  in  1  instruction reads rt (R-type, store, branch).
- id_reg_write  in  1  instruction writes the register file.
- id_mem_read  in  1  instruction is a load.
- id_waddr  in  REG_ADDR_W  destination after the reg_dst mux.
- redirect  in  1  taken branch or jump in MEM (branch_EX_MEM&zero_EX_MEM | jump_EX_MEM).
- stall_cnt_clr  in  1  synchronous clear of stall_cnt.
- stall_if_id  out  1  hold PC and IF/ID.
- flush_if_id  out  1  load NOP into IF/ID.
- flush_id_ex  out  1  load bubble into ID/EX (stall or redirect).
- flush_ex_mem  out  1  load bubble into EX/MEM.
- fwd_a_sel  out  2  EX operand A source: 0 regfile, 1 EX/MEM alu_out, 2 MEM/WB wdata.
- fwd_b_sel  out  2  same for operand B.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Scoreboard entry = {valid, reg_write, mem_read, waddr}, one each for EX, MEM, WB. An entry is a producer only if valid & reg_write & waddr!=0.
- Register 0 never matches, never stalls, never forwards.
- Hazard check is combinational on the ID inputs. A source matches an entry if use bit & id_valid & producer & addr equal.
- With FWD_EN=1:
  - Match EX with mem_read=1 → load-use stall.
  - Match EX, non-load → sel 1.
  - Else match MEM → sel 2.
  - Else match WB → stall if RF_WRITE_THROUGH=0; otherwise sel 0.
  - If both EX and MEM match, the youngest (EX) wins.
- With FWD_EN=0: any match in EX or MEM, or in WB when RF_WRITE_THROUGH=0, → stall. Selects are always 0.
- stall = hazard & ~redirect.
- stall_if_id = stall.
- flush_id_ex = stall | redirect.
- flush_if_id = flush_ex_mem = redirect. Redirect has priority over stall.
- All strobes are forced to 0 while enable=0.
- Scoreboard update, on posedge clk only when enable=1:
  - redirect: EX←invalid, MEM←invalid, WB←MEM.
  - stall: EX←invalid (bubble), MEM←EX, WB←MEM.
  - otherwise: EX←{id_valid, id_reg_write, id_mem_read, id_waddr}, MEM←EX, WB←MEM.
- fwd_a_sel/fwd_b_sel are registered when enable=1 and aligned with the consumer entering EX. They load 0 on stall or redirect (bubble), otherwise the computed select. Latency is 1 cycle after ID decode.
- enable=0 freezes scoreboard, selects and counter.
- stall_cnt: stall_cnt_clr has priority and loads 0. Otherwise it increments when enable & stall_if_id, and holds at 2^CNT_W-1.
- arst=1, any time including mid-stall: all scoreboard entries invalid; fwd_a_sel=fwd_b_sel=0; stall_cnt=0. All strobes read 0 as soon as arst asserts.
- The pipeline resumes with an empty scoreboard on the first enabled edge after arst falls.

Test Plan:
- FWD_EN=1: add $3,$1,$2 then sub $4,$3,$5 back-to-back → no stall; fwd_a_sel=1 on the cycle sub is in EX; fwd_b_sel=0.
- FWD_EN=1: lw $3,0($0) then add $4,$3,$3 → stall_if_id=1 and flush_id_ex=1 for exactly 1 cycle. Then fwd_a_sel=fwd_b_sel=2. stall_cnt=1.
- FWD_EN=0: add $3 then add $4,$3,$0 → 2 stall cycles (producer in EX, then MEM); 3 with RF_WRITE_THROUGH=0. Selects remain 0.
- Write to $0 followed by read of $0 → no stall; selects 0.
- redirect=1 while a load-use hazard is in ID → stall_if_id=0. flush_if_id, flush_id_ex and flush_ex_mem are all 1. EX and MEM entries become invalid, and a following reader of that load's register does not stall.
- CNT_W=2 with 5 consecutive stalls → stall_cnt saturates at 3. stall_cnt_clr → 0. arst asserted mid-stall → outputs 0 immediately, scoreboard empty after release.
